basilisk_issue: RTL and testbench
=================================

# basilisk_issue

Issue stage for the basilisk FPU. Accepts one RV32F arithmetic request per cycle as raw 32-bit operands and unpacks each operand into float fields and classification conditions. Builds the matching add, multiply, divide or sqrt command and presents it on that unit's registered valid/ready output port. Divide and sqrt share one iterative datapath, so at most one of them is outstanding at a time.

## Interface
- No parameters. Widths are fixed by the rv32, rv32f and fpu packages.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_op  in  4  0 FADD, 1 FSUB, 2 FMUL, 3 FMADD, 4 FMSUB, 5 FNMSUB, 6 FNMADD, 7 FDIV, 8 FSQRT; 9-15 illegal
- req_rs1, req_rs2, req_rs3  in  32  raw IEEE-754 single operands a, b, c
- req_frm  in  3  instruction rounding mode; 3'b111 means dynamic
- csr_frm  in  3  fcsr rounding mode, used when req_frm is dynamic
- add_valid / add_ready / add_command  out / in / basilisk_add_command_t  add-unit stream
- mult_valid / mult_ready / mult_command  out / in / basilisk_mult_command_t  multiply-unit stream
- divide_valid / divide_ready / divide_command  out / in / basilisk_divide_command_t  divide stream
- sqrt_valid / sqrt_ready / sqrt_command  out / in / basilisk_sqrt_command_t  sqrt stream
- div_sqrt_done  in  1  one-cycle pulse from the shared divide/sqrt unit when it completes
- illegal_op  out  1  one-cycle pulse when an illegal request is consumed

## Operation
- Unpacking: sign = bit 31, exponent = bits 30:23, mantissa = bits 22:0.
- Conditions per operand:
  - zero: exp 0, mant 0
  - subnormal: exp 0, mant ≠ 0
  - inf: exp 255, mant 0
  - nan: exp 255, mant ≠ 0
  - signaling: nan with mantissa bit 22 = 0
- Round mode: req_frm if 0-4. If req_frm = 7, use csr_frm; csr_frm must then be 0-4.
  - A resolved mode of 5, 6 or 7, or req_op ≥ 9, makes the request illegal.
  - An illegal request is consumed without waiting on any slot, emits no command, and pulses illegal_op on the next cycle.
- Routing and sign manipulation, applied before conditions are latched:
  - FADD: add, a and b unmodified.
  - FSUB: add, b.sign inverted.
  - FMUL: mult, enable_macc = 0, c fields/conditions zeroed.
  - FMADD: mult, enable_macc = 1.
  - FMSUB: mult, enable_macc = 1, c.sign inverted.
  - FNMSUB: mult, enable_macc = 1, a.sign inverted.
  - FNMADD: mult, enable_macc = 1, a.sign and c.sign inverted.
  - FDIV: divide, a / b.
  - FSQRT: sqrt, operand a.
- Each output stream is a single-entry register slot (valid + command). The slot loads on request accept and clears on the valid && ready handshake.
- div_sqrt_busy flag:
  - Set when an FDIV or FSQRT request is accepted.
  - Cleared on div_sqrt_done.
  - A done pulse while not busy is ignored.
- req_ready is combinational from slot state and downstream ready; it has no combinational dependence on req_valid. It is high when any of these holds:
  - req_op/resolved mode is illegal.
  - The target slot is empty, or full with its ready high this cycle (pass-through refill).
  - For FDIV/FSQRT, additionally requires !div_sqrt_busy.
- Ordering is preserved within a stream. Streams are independent; the retire logic reorders results across streams.

## Timing
- Reset (asynchronous, rst_n low): all *_valid = 0, illegal_op = 0, div_sqrt_busy = 0. Command registers are don't-care. req_ready follows from empty slots.
- Latency: request handshake in cycle N gives command valid in cycle N+1.
- Throughput: one request per cycle per stream when downstream holds ready high.
- Command payload is stable while valid is high and ready is low.
- Reset mid-operation: pending slots and busy are discarded immediately. No command survives reset.
- div_sqrt_done in cycle N allows a new FDIV/FSQRT to be accepted in cycle N+1. There is no combinational path from done to req_ready.

## Test plan
- FADD, rs1 = 0x3F800000, rs2 = 0x40000000, frm = 0 -> next cycle add_valid = 1:
  - a = {0, 127, 0}, b = {0, 128, 0}
  - all conditions clear, mode RNE
- FNMADD, rs1 = 0x3F800000, rs2 = 0x3F800000, rs3 = 0xC0000000, frm = 7, csr_frm = 1 -> mult_command:
  - enable_macc = 1, a.sign = 1, c.sign = 0, mode RTZ
- add_ready held low across two back-to-back FADDs:
  - first command stays stable
  - req_ready low for the second
  - add_ready raised -> second command appears one cycle after the first handshake
- FDIV accepted, then FSQRT presented:
  - req_ready stays low until div_sqrt_done pulses
  - FSQRT accepted the cycle after the pulse
  - sqrt_valid high the cycle after that
- Operand classification:
  - rs1 = 0x7FA00000 -> nan, signaling
  - rs1 = 0x7FC00000 -> quiet nan
  - rs2 = 0x00000001 -> subnormal
  - rs2 = 0x80000000 -> zero, sign 1
- Illegal requests and reset:
  - req_frm = 5 -> illegal_op pulses for one cycle, no *_valid
  - req_op = 12 -> same
  - rst_n pulled low while mult_valid = 1 -> mult_valid drops immediately and stays 0 after release until a new request

Source files
------------

// File: rtl/basilisk_issue.sv
// Issue stage for the basilisk FPU: decodes RV32F arithmetic requests, unpacks and
// classifies operands, and loads per-unit single-entry command slots.

package basilisk_pkg;

    localparam logic [3:0] OP_FADD   = 4'd0;
    localparam logic [3:0] OP_FSUB   = 4'd1;
    localparam logic [3:0] OP_FMUL   = 4'd2;
    localparam logic [3:0] OP_FMADD  = 4'd3;
    localparam logic [3:0] OP_FMSUB  = 4'd4;
    localparam logic [3:0] OP_FNMSUB = 4'd5;
    localparam logic [3:0] OP_FNMADD = 4'd6;
    localparam logic [3:0] OP_FDIV   = 4'd7;
    localparam logic [3:0] OP_FSQRT  = 4'd8;

    localparam logic [2:0] FRM_DYN   = 3'b111;

    typedef enum logic [2:0] {
        RND_RNE = 3'd0,
        RND_RTZ = 3'd1,
        RND_RDN = 3'd2,
        RND_RUP = 3'd3,
        RND_RMM = 3'd4
    } basilisk_round_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } basilisk_float_t;

    typedef struct packed {
        logic zero;
        logic subnormal;
        logic inf;
        logic nan;
        logic signaling;
    } basilisk_cond_t;

    typedef struct packed {
        basilisk_float_t a;
        basilisk_float_t b;
        basilisk_cond_t  a_cond;
        basilisk_cond_t  b_cond;
        basilisk_round_t mode;
    } basilisk_add_command_t;

    typedef struct packed {
        basilisk_float_t a;
        basilisk_float_t b;
        basilisk_float_t c;
        basilisk_cond_t  a_cond;
        basilisk_cond_t  b_cond;
        basilisk_cond_t  c_cond;
        logic            enable_macc;
        basilisk_round_t mode;
    } basilisk_mult_command_t;

    typedef struct packed {
        basilisk_float_t a;
        basilisk_float_t b;
        basilisk_cond_t  a_cond;
        basilisk_cond_t  b_cond;
        basilisk_round_t mode;
    } basilisk_divide_command_t;

    typedef struct packed {
        basilisk_float_t a;
        basilisk_cond_t  a_cond;
        basilisk_round_t mode;
    } basilisk_sqrt_command_t;

    function automatic basilisk_float_t unpack_float(input logic [31:0] raw);
        basilisk_float_t f;
        f.sign     = raw[31];
        f.exponent = raw[30:23];
        f.mantissa = raw[22:0];
        return f;
    endfunction

    function automatic basilisk_cond_t classify(input basilisk_float_t f);
        basilisk_cond_t c;
        logic exp_zero;
        logic exp_ones;
        logic mant_zero;
        exp_zero    = (f.exponent == 8'd0);
        exp_ones    = (f.exponent == 8'hFF);
        mant_zero   = (f.mantissa == 23'd0);
        c.zero      = exp_zero && mant_zero;
        c.subnormal = exp_zero && !mant_zero;
        c.inf       = exp_ones && mant_zero;
        c.nan       = exp_ones && !mant_zero;
        c.signaling = exp_ones && !mant_zero && !f.mantissa[22];
        return c;
    endfunction

endpackage

module basilisk_issue
    import basilisk_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [3:0]               req_op,
    input  logic [31:0]              req_rs1,
    input  logic [31:0]              req_rs2,
    input  logic [31:0]              req_rs3,
    input  logic [2:0]               req_frm,
    input  logic [2:0]               csr_frm,

    output logic                     add_valid,
    input  logic                     add_ready,
    output basilisk_add_command_t    add_command,

    output logic                     mult_valid,
    input  logic                     mult_ready,
    output basilisk_mult_command_t   mult_command,

    output logic                     divide_valid,
    input  logic                     divide_ready,
    output basilisk_divide_command_t divide_command,

    output logic                     sqrt_valid,
    input  logic                     sqrt_ready,
    output basilisk_sqrt_command_t   sqrt_command,

    input  logic                     div_sqrt_done,
    output logic                     illegal_op
);

    // Handshake: a transfer happens on a rising clk edge where valid && ready are
    // both high; a producer holds valid and payload steady until that edge.

    logic [2:0]      mode_raw;
    logic            mode_ok;
    logic            op_ok;
    logic            illegal;
    basilisk_round_t mode;

    logic            is_add;
    logic            is_mult;
    logic            is_div;
    logic            is_sqrt;

    logic            add_free;
    logic            mult_free;
    logic            divide_free;
    logic            sqrt_free;
    logic            div_sqrt_busy;

    logic            accept;
    logic            acc_add;
    logic            acc_mult;
    logic            acc_div;
    logic            acc_sqrt;

    basilisk_float_t fa;
    basilisk_float_t fb;
    basilisk_float_t fc;
    basilisk_cond_t  ca;
    basilisk_cond_t  cb;
    basilisk_cond_t  cc;
    logic            macc;

    always_comb begin
        mode_raw = (req_frm == FRM_DYN) ? csr_frm : req_frm;
        mode_ok  = (mode_raw <= 3'd4);
        mode     = basilisk_round_t'(mode_raw);
        op_ok    = (req_op <= OP_FSQRT);
        illegal  = !(mode_ok && op_ok);
        is_add   = !illegal && ((req_op == OP_FADD) || (req_op == OP_FSUB));
        is_mult  = !illegal && (req_op >= OP_FMUL) && (req_op <= OP_FNMADD);
        is_div   = !illegal && (req_op == OP_FDIV);
        is_sqrt  = !illegal && (req_op == OP_FSQRT);
    end

    // A full slot whose consumer is ready this cycle can be refilled in the same cycle.
    assign add_free    = !add_valid    || add_ready;
    assign mult_free   = !mult_valid   || mult_ready;
    assign divide_free = !divide_valid || divide_ready;
    assign sqrt_free   = !sqrt_valid   || sqrt_ready;

    assign req_ready = illegal
                     || (is_add  && add_free)
                     || (is_mult && mult_free)
                     || (is_div  && divide_free && !div_sqrt_busy)
                     || (is_sqrt && sqrt_free   && !div_sqrt_busy);

    assign accept   = req_valid && req_ready;
    assign acc_add  = accept && is_add;
    assign acc_mult = accept && is_mult;
    assign acc_div  = accept && is_div;
    assign acc_sqrt = accept && is_sqrt;

    // Sign manipulation precedes classification so the latched conditions describe
    // the operands exactly as the unit will see them.
    always_comb begin
        fa   = unpack_float(req_rs1);
        fb   = unpack_float(req_rs2);
        fc   = unpack_float(req_rs3);
        macc = 1'b0;
        case (req_op)
            OP_FSUB:   fb.sign = !fb.sign;
            OP_FMUL:   fc = '0;
            OP_FMADD:  macc = 1'b1;
            OP_FMSUB: begin
                macc    = 1'b1;
                fc.sign = !fc.sign;
            end
            OP_FNMSUB: begin
                macc    = 1'b1;
                fa.sign = !fa.sign;
            end
            OP_FNMADD: begin
                macc    = 1'b1;
                fa.sign = !fa.sign;
                fc.sign = !fc.sign;
            end
            default: ;
        endcase
        ca = classify(fa);
        cb = classify(fb);
        cc = (req_op == OP_FMUL) ? '0 : classify(fc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_valid     <= 1'b0;
            mult_valid    <= 1'b0;
            divide_valid  <= 1'b0;
            sqrt_valid    <= 1'b0;
            div_sqrt_busy <= 1'b0;
            illegal_op    <= 1'b0;
        end else begin
            if (acc_add)
                add_valid <= 1'b1;
            else if (add_valid && add_ready)
                add_valid <= 1'b0;

            if (acc_mult)
                mult_valid <= 1'b1;
            else if (mult_valid && mult_ready)
                mult_valid <= 1'b0;

            if (acc_div)
                divide_valid <= 1'b1;
            else if (divide_valid && divide_ready)
                divide_valid <= 1'b0;

            if (acc_sqrt)
                sqrt_valid <= 1'b1;
            else if (sqrt_valid && sqrt_ready)
                sqrt_valid <= 1'b0;

            // Acceptance needs !busy, so set and done can never collide meaningfully.
            if (acc_div || acc_sqrt)
                div_sqrt_busy <= 1'b1;
            else if (div_sqrt_done)
                div_sqrt_busy <= 1'b0;

            illegal_op <= req_valid && illegal;
        end
    end

    // Payload registers carry no reset; they are qualified by the valid flags above.
    always_ff @(posedge clk) begin
        if (acc_add) begin
            add_command.a      <= fa;
            add_command.b      <= fb;
            add_command.a_cond <= ca;
            add_command.b_cond <= cb;
            add_command.mode   <= mode;
        end
        if (acc_mult) begin
            mult_command.a           <= fa;
            mult_command.b           <= fb;
            mult_command.c           <= fc;
            mult_command.a_cond      <= ca;
            mult_command.b_cond      <= cb;
            mult_command.c_cond      <= cc;
            mult_command.enable_macc <= macc;
            mult_command.mode        <= mode;
        end
        if (acc_div) begin
            divide_command.a      <= fa;
            divide_command.b      <= fb;
            divide_command.a_cond <= ca;
            divide_command.b_cond <= cb;
            divide_command.mode   <= mode;
        end
        if (acc_sqrt) begin
            sqrt_command.a      <= fa;
            sqrt_command.a_cond <= ca;
            sqrt_command.mode   <= mode;
        end
    end

endmodule

// File: tb/tb_basilisk_issue.sv
// Directed bench for basilisk_issue: expected commands are queued per stream at
// request time and a negedge monitor pops them on every output handshake.

module tb_basilisk_issue;
    import basilisk_pkg::*;

    localparam int AW = $bits(basilisk_add_command_t);
    localparam int MW = $bits(basilisk_mult_command_t);
    localparam int DW = $bits(basilisk_divide_command_t);
    localparam int SW = $bits(basilisk_sqrt_command_t);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0;
    logic req_ready;
    logic [3:0] req_op = '0;
    logic [31:0] req_rs1 = '0, req_rs2 = '0, req_rs3 = '0;
    logic [2:0] req_frm = '0, csr_frm = '0;
    logic add_valid, mult_valid, divide_valid, sqrt_valid;
    logic add_ready = 1'b1, mult_ready = 1'b1, divide_ready = 1'b1, sqrt_ready = 1'b1;
    basilisk_add_command_t    add_command;
    basilisk_mult_command_t   mult_command;
    basilisk_divide_command_t divide_command;
    basilisk_sqrt_command_t   sqrt_command;
    logic div_sqrt_done = 1'b0;
    logic illegal_op;

    int n_checks = 0;
    int n_fail = 0;
    int ill_pending = 0;
    logic [AW-1:0] exp_add_q[$];
    logic [MW-1:0] exp_mult_q[$];
    logic [DW-1:0] exp_div_q[$];
    logic [SW-1:0] exp_sqrt_q[$];

    basilisk_issue dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3),
        .req_frm(req_frm), .csr_frm(csr_frm),
        .add_valid(add_valid), .add_ready(add_ready), .add_command(add_command),
        .mult_valid(mult_valid), .mult_ready(mult_ready), .mult_command(mult_command),
        .divide_valid(divide_valid), .divide_ready(divide_ready), .divide_command(divide_command),
        .sqrt_valid(sqrt_valid), .sqrt_ready(sqrt_ready), .sqrt_command(sqrt_command),
        .div_sqrt_done(div_sqrt_done), .illegal_op(illegal_op)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check_vec(name, 128'(act), 128'(exp));
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        check_vec(name, 128'(act), 128'(exp));
    endtask

    function automatic basilisk_float_t mkf(input logic s, input logic [7:0] e, input logic [22:0] m);
        basilisk_float_t f;
        f.sign = s;
        f.exponent = e;
        f.mantissa = m;
        return f;
    endfunction

    function automatic basilisk_cond_t cnd(input logic z, input logic sub, input logic inf,
                                           input logic nan, input logic sig);
        basilisk_cond_t c;
        c.zero = z;
        c.subnormal = sub;
        c.inf = inf;
        c.nan = nan;
        c.signaling = sig;
        return c;
    endfunction

    function automatic logic [127:0] mk_add(input basilisk_float_t a, input basilisk_float_t b,
                                            input basilisk_cond_t ca, input basilisk_cond_t cb,
                                            input basilisk_round_t m);
        basilisk_add_command_t x;
        x.a = a; x.b = b; x.a_cond = ca; x.b_cond = cb; x.mode = m;
        return 128'(x);
    endfunction

    function automatic logic [127:0] mk_mult(input basilisk_float_t a, input basilisk_float_t b,
                                             input basilisk_float_t c, input basilisk_cond_t ca,
                                             input basilisk_cond_t cb, input basilisk_cond_t cc,
                                             input logic macc, input basilisk_round_t m);
        basilisk_mult_command_t x;
        x.a = a; x.b = b; x.c = c; x.a_cond = ca; x.b_cond = cb; x.c_cond = cc;
        x.enable_macc = macc; x.mode = m;
        return 128'(x);
    endfunction

    function automatic logic [127:0] mk_div(input basilisk_float_t a, input basilisk_float_t b,
                                            input basilisk_round_t m);
        basilisk_divide_command_t x;
        x.a = a; x.b = b; x.a_cond = '0; x.b_cond = '0; x.mode = m;
        return 128'(x);
    endfunction

    function automatic logic [127:0] mk_sqrt(input basilisk_float_t a, input basilisk_round_t m);
        basilisk_sqrt_command_t x;
        x.a = a; x.a_cond = '0; x.mode = m;
        return 128'(x);
    endfunction

    // Driver tasks
    task automatic drive_req(input logic [3:0] op, input logic [31:0] r1, input logic [31:0] r2,
                             input logic [31:0] r3, input logic [2:0] frm, input logic [2:0] csr);
        req_op = op; req_rs1 = r1; req_rs2 = r2; req_rs3 = r3;
        req_frm = frm; csr_frm = csr; req_valid = 1'b1;
    endtask

    task automatic push_exp(input int stream, input logic [127:0] e);
        case (stream)
            0: exp_add_q.push_back(e[AW-1:0]);
            1: exp_mult_q.push_back(e[MW-1:0]);
            2: exp_div_q.push_back(e[DW-1:0]);
            3: exp_sqrt_q.push_back(e[SW-1:0]);
            default: ill_pending++;
        endcase
    endtask

    // Called away from the rising edge; returns #1 after the accepting edge.
    task automatic wait_accept(input int stream, input logic [127:0] e);
        int n = 0;
        #1;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_bit("accept_ready", req_ready, 1'b1);
        if (req_ready) push_exp(stream, e);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] r3, input logic [2:0] frm, input logic [2:0] csr,
                        input int stream, input logic [127:0] e);
        @(posedge clk);
        #1 drive_req(op, r1, r2, r3, frm, csr);
        wait_accept(stream, e);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (add_valid && add_ready) begin
                check_int("add_expected", exp_add_q.size() > 0 ? 1 : 0, 1);
                if (exp_add_q.size() > 0)
                    check_vec("add_cmd", 128'(add_command), 128'(exp_add_q.pop_front()));
            end
            if (mult_valid && mult_ready) begin
                check_int("mult_expected", exp_mult_q.size() > 0 ? 1 : 0, 1);
                if (exp_mult_q.size() > 0)
                    check_vec("mult_cmd", 128'(mult_command), 128'(exp_mult_q.pop_front()));
            end
            if (divide_valid && divide_ready) begin
                check_int("div_expected", exp_div_q.size() > 0 ? 1 : 0, 1);
                if (exp_div_q.size() > 0)
                    check_vec("div_cmd", 128'(divide_command), 128'(exp_div_q.pop_front()));
            end
            if (sqrt_valid && sqrt_ready) begin
                check_int("sqrt_expected", exp_sqrt_q.size() > 0 ? 1 : 0, 1);
                if (exp_sqrt_q.size() > 0)
                    check_vec("sqrt_cmd", 128'(sqrt_command), 128'(exp_sqrt_q.pop_front()));
            end
            if (illegal_op) begin
                check_int("illegal_expected", ill_pending > 0 ? 1 : 0, 1);
                if (ill_pending > 0) ill_pending--;
            end
        end
    end

    localparam basilisk_cond_t CN = '0;

    logic [127:0] e1, e2;

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        check_vec("reset_valids", 128'({add_valid, mult_valid, divide_valid, sqrt_valid}), 128'(0));
        check_bit("reset_illegal", illegal_op, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_bit("reset_req_ready", req_ready, 1'b1);

        // Stray done while idle must be ignored.
        @(posedge clk); #1 div_sqrt_done = 1'b1;
        @(posedge clk); #1 div_sqrt_done = 1'b0;

        // FADD 1.0 + 2.0, one-cycle latency
        send(OP_FADD, 32'h3F800000, 32'h40000000, 32'h0, 3'd0, 3'd0, 0,
             mk_add(mkf(0, 127, 0), mkf(0, 128, 0), CN, CN, RND_RNE));
        @(negedge clk);
        check_bit("fadd_latency", add_valid, 1'b1);

        // FNMADD with dynamic rounding from csr
        send(OP_FNMADD, 32'h3F800000, 32'h3F800000, 32'hC0000000, 3'd7, 3'd1, 1,
             mk_mult(mkf(1, 127, 0), mkf(0, 127, 0), mkf(0, 128, 0), CN, CN, CN, 1'b1, RND_RTZ));
        @(negedge clk);
        check_bit("fnmadd_valid", mult_valid, 1'b1);

        // Sign manipulation on the remaining opcodes
        send(OP_FSUB, 32'h40000000, 32'hBF800000, 32'h0, 3'd4, 3'd0, 0,
             mk_add(mkf(0, 128, 0), mkf(0, 127, 0), CN, CN, RND_RMM));
        send(OP_FMSUB, 32'h00000000, 32'h3F800000, 32'hFF800000, 3'd2, 3'd0, 1,
             mk_mult(mkf(0, 0, 0), mkf(0, 127, 0), mkf(0, 255, 0),
                     cnd(1, 0, 0, 0, 0), CN, cnd(0, 0, 1, 0, 0), 1'b1, RND_RDN));
        send(OP_FNMSUB, 32'h40400000, 32'h40400000, 32'h3F800000, 3'd3, 3'd0, 1,
             mk_mult(mkf(1, 128, 23'h400000), mkf(0, 128, 23'h400000), mkf(0, 127, 0),
                     CN, CN, CN, 1'b1, RND_RUP));

        // Classification: signaling nan, subnormal, quiet nan, negative zero, FMUL clears c
        send(OP_FADD, 32'h7FA00000, 32'h00000001, 32'h0, 3'd0, 3'd0, 0,
             mk_add(mkf(0, 255, 23'h200000), mkf(0, 0, 1),
                    cnd(0, 0, 0, 1, 1), cnd(0, 1, 0, 0, 0), RND_RNE));
        send(OP_FMUL, 32'h7FC00000, 32'h80000000, 32'h12345678, 3'd3, 3'd0, 1,
             mk_mult(mkf(0, 255, 23'h400000), mkf(1, 0, 0), mkf(0, 0, 0),
                     cnd(0, 0, 0, 1, 0), cnd(1, 0, 0, 0, 0), CN, 1'b0, RND_RUP));

        // Back-to-back FADDs against a stalled add unit
        @(posedge clk); #1 add_ready = 1'b0;
        e1 = mk_add(mkf(0, 128, 23'h400000), mkf(0, 129, 0), CN, CN, RND_RDN);
        e2 = mk_add(mkf(1, 130, 23'h200000), mkf(0, 126, 0), CN, CN, RND_RMM);
        send(OP_FADD, 32'h40400000, 32'h40800000, 32'h0, 3'd2, 3'd0, 0, e1);
        @(posedge clk);
        #1 drive_req(OP_FADD, 32'hC1200000, 32'h3F000000, 32'h0, 3'd7, 3'd4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_bit("stall_req_ready", req_ready, 1'b0);
            check_bit("stall_add_valid", add_valid, 1'b1);
            check_vec("stall_add_cmd", 128'(add_command), e1);
        end
        @(posedge clk);
        #1 add_ready = 1'b1;
        wait_accept(0, e2);
        @(negedge clk);
        check_bit("refill_add_valid", add_valid, 1'b1);
        check_vec("refill_add_cmd", 128'(add_command), e2);

        // FDIV blocks a following FSQRT until done
        send(OP_FDIV, 32'h40C00000, 32'h40000000, 32'h0, 3'd0, 3'd0, 2,
             mk_div(mkf(0, 129, 23'h400000), mkf(0, 128, 0), RND_RNE));
        @(posedge clk);
        #1 drive_req(OP_FSQRT, 32'h40800000, 32'h0, 32'h0, 3'd1, 3'd0);
        repeat (2) begin
            @(negedge clk);
            check_bit("sqrt_blocked", req_ready, 1'b0);
        end
        @(posedge clk); #1 div_sqrt_done = 1'b1;
        @(negedge clk);
        check_bit("done_no_comb_path", req_ready, 1'b0);
        @(posedge clk); #1 div_sqrt_done = 1'b0;
        @(negedge clk);
        check_bit("sqrt_ready_after_done", req_ready, 1'b1);
        push_exp(3, mk_sqrt(mkf(0, 129, 0), RND_RTZ));
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        check_bit("sqrt_valid", sqrt_valid, 1'b1);
        @(posedge clk); #1 div_sqrt_done = 1'b1;
        @(posedge clk); #1 div_sqrt_done = 1'b0;

        // Illegal requests: bad static mode, bad opcode, bad dynamic mode
        send(OP_FADD, 32'h3F800000, 32'h3F800000, 32'h0, 3'd5, 3'd0, 4, '0);
        @(negedge clk);
        check_bit("illegal_frm_pulse", illegal_op, 1'b1);
        check_vec("illegal_no_valid", 128'({add_valid, mult_valid, divide_valid, sqrt_valid}), 128'(0));
        @(negedge clk);
        check_bit("illegal_frm_one_cycle", illegal_op, 1'b0);
        send(4'd12, 32'h3F800000, 32'h3F800000, 32'h0, 3'd0, 3'd0, 4, '0);
        @(negedge clk);
        check_bit("illegal_op_pulse", illegal_op, 1'b1);
        check_vec("illegal_op_no_valid", 128'({add_valid, mult_valid, divide_valid, sqrt_valid}), 128'(0));
        send(OP_FDIV, 32'h3F800000, 32'h3F800000, 32'h0, 3'd7, 3'd6, 4, '0);
        @(negedge clk);
        check_bit("illegal_dyn_pulse", illegal_op, 1'b1);

        // Illegal request consumed even while its nominal slot is stalled
        @(posedge clk); #1 add_ready = 1'b0;
        send(OP_FADD, 32'h3F800000, 32'h40000000, 32'h0, 3'd0, 3'd0, 0,
             mk_add(mkf(0, 127, 0), mkf(0, 128, 0), CN, CN, RND_RNE));
        send(4'd9, 32'h0, 32'h0, 32'h0, 3'd0, 3'd0, 4, '0);
        @(negedge clk);
        check_bit("illegal_while_stalled", illegal_op, 1'b1);
        @(posedge clk); #1 add_ready = 1'b1;

        // Asynchronous reset discards a pending mult command
        @(posedge clk); #1 mult_ready = 1'b0;
        send(OP_FMUL, 32'h3F800000, 32'h40000000, 32'h0, 3'd0, 3'd0, 1,
             mk_mult(mkf(0, 127, 0), mkf(0, 128, 0), mkf(0, 0, 0), CN, CN, CN, 1'b0, RND_RNE));
        @(negedge clk);
        check_bit("mult_pending", mult_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_bit("reset_async_drop", mult_valid, 1'b0);
        exp_mult_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mult_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_bit("mult_stays_low", mult_valid, 1'b0);
        end
        send(OP_FMUL, 32'h40400000, 32'hBF800000, 32'h0, 3'd1, 3'd0, 1,
             mk_mult(mkf(0, 128, 23'h400000), mkf(1, 127, 0), mkf(0, 0, 0),
                     CN, CN, CN, 1'b0, RND_RTZ));
        @(negedge clk);
        check_bit("mult_after_reset", mult_valid, 1'b1);

        // Final report
        repeat (5) @(negedge clk);
        check_int("add_q_drained", exp_add_q.size(), 0);
        check_int("mult_q_drained", exp_mult_q.size(), 0);
        check_int("div_q_drained", exp_div_q.size(), 0);
        check_int("sqrt_q_drained", exp_sqrt_q.size(), 0);
        check_int("illegal_drained", ill_pending, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
